lopd_unit: RTL and testbench

Registered leading-one position detector (LOPD) for the floating-point datapath. Each cycle it finds the most-significant set bit of a `SIZE_DATA`-bit word and flags an all-zero word. A side-band address/tag travels with the data so that downstream normalization logic can match each result to its operand. All three outputs update together, one clock after the inputs.

---
 rtl/lopd_unit.sv | 97 +++++++++
 tb/tb_lopd_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lopd_unit.sv
// lopd_unit
// Registered leading-one position detector for the floating-point datapath.
// Each clock it scans a SIZE_DATA-bit word for its most-significant set bit.
// It also flags an all-zero word. A side-band address/tag is carried alongside
// so downstream normalization can pair every result with its operand. All
// outputs are registered together, one clock after the inputs.
//
// Ports:
//   i_clk           in   1          rising-edge clock
//   i_rst_n         in   1          asynchronous active-low reset
//   i_addr          in   SIZE_DATA  tag/address accompanying i_data
//   i_data          in   SIZE_DATA  word to scan
//   o_addr          out  SIZE_DATA  registered copy of i_addr
//   o_one_position  out  SIZE_LOP   bit index (0 = LSB) of the highest 1
//   o_zero_flag     out  1          1 when the registered word is all zeros
//
// SIZE_DATA must be a power of two, at least 4.
// SIZE_LOP must equal $clog2(SIZE_DATA).

module lopd_unit #(
   parameter int SIZE_DATA = 32,
   parameter int SIZE_LOP  = $clog2(SIZE_DATA)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [SIZE_DATA-1:0] i_addr,
   input  logic [SIZE_DATA-1:0] i_data,
   output logic [SIZE_DATA-1:0] o_addr,
   output logic [SIZE_LOP-1:0]  o_one_position,
   output logic                 o_zero_flag
);

   localparam int NUM_LEAF = SIZE_DATA / 4;
   localparam int LEVELS   = SIZE_LOP - 2;

   // Level 0 holds the 4-bit leaf detectors. Level LEVELS holds the single root.
   // Entries beyond a level's node count are unused and held at zero.
   logic [SIZE_LOP-1:0] node_idx [LEVELS+1][NUM_LEAF];
   logic                node_vld [LEVELS+1][NUM_LEAF];

   logic [SIZE_LOP-1:0] tree_idx;
   logic                tree_vld;

   // The tree is built bottom-up. A leaf yields {valid, 2-bit index} for its nibble.
   // Each merge prefers the upper half when it holds a 1, which sets the new
   // index MSB. Otherwise it takes the lower half, where the new MSB stays 0.
   // An invalid leaf reports index 0, so an all-zero word reaches the root
   // with index 0.
   always_comb begin
      for (int l = 0; l <= LEVELS; l++) begin
         for (int n = 0; n < NUM_LEAF; n++) begin
            node_idx[l][n] = '0;
            node_vld[l][n] = 1'b0;
         end
      end

      for (int n = 0; n < NUM_LEAF; n++) begin
         node_vld[0][n] = |i_data[4*n +: 4];
         if (i_data[4*n+3])
            node_idx[0][n] = SIZE_LOP'(3);
         else if (i_data[4*n+2])
            node_idx[0][n] = SIZE_LOP'(2);
         else if (i_data[4*n+1])
            node_idx[0][n] = SIZE_LOP'(1);
         else
            node_idx[0][n] = SIZE_LOP'(0);
      end

      for (int l = 1; l <= LEVELS; l++) begin
         for (int n = 0; n < (NUM_LEAF >> l); n++) begin
            node_vld[l][n] = node_vld[l-1][2*n+1] | node_vld[l-1][2*n];
            if (node_vld[l-1][2*n+1])
               node_idx[l][n] = node_idx[l-1][2*n+1] | (SIZE_LOP'(1) << (l+1));
            else
               node_idx[l][n] = node_idx[l-1][2*n];
         end
      end
   end

   assign tree_idx = node_idx[LEVELS][0];
   assign tree_vld = node_vld[LEVELS][0];

   // Single output register stage keeps the tag, position and flag aligned.
   // The reset values match a registered all-zero word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_addr         <= '0;
         o_one_position <= '0;
         o_zero_flag    <= 1'b1;
      end else begin
         o_addr         <= i_addr;
         o_one_position <= tree_vld ? tree_idx : '0;
         o_zero_flag    <= ~tree_vld;
      end
   end

endmodule

// File: tb/tb_lopd_unit.sv
// tb_lopd_unit
// Self-checking bench for lopd_unit at the default 32-bit width.
// Expected results come from hand-filled tables and hand-written sequences.
// They also come from a reference model. The model scans the word from the MSB
// downwards for the first set bit.

module tb_lopd_unit;

   localparam int W  = 32;
   localparam int LW = 5;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  addr_in;
   logic [W-1:0]  data_in;
   logic [W-1:0]  addr_out;
   logic [LW-1:0] pos_out;
   logic          zero_out;

   logic [W-1:0]  exp_addr;
   logic [LW-1:0] exp_pos;
   logic          exp_zero;

   int errors;
   int checks;

   typedef struct {
      string        name;
      logic [W-1:0] addr;
      logic [W-1:0] data;
      int           pos;
      logic         zero;
   } vector_t;

   vector_t vectors [8];

   lopd_unit #(.SIZE_DATA(W), .SIZE_LOP(LW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_addr         (addr_in),
      .i_data         (data_in),
      .o_addr         (addr_out),
      .o_one_position (pos_out),
      .o_zero_flag    (zero_out)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the index of the highest set bit, or 0 for a zero word.
   function automatic int refPos(input logic [W-1:0] d);
      for (int b = W-1; b >= 0; b--)
         if (d[b]) return b;
      return 0;
   endfunction

   // Drive one operand and let it cross a rising edge. Then record what the
   // outputs must show one cycle later. Sampling happens 1 ns after the edge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] d);
      addr_in = a;
      data_in = d;
      @(posedge clk);
      #1;
      exp_addr = a;
      exp_pos  = LW'(refPos(d));
      exp_zero = (d == '0);
   endtask

   task automatic checkOne(input string tag, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, ".addr"}, longint'(addr_out), longint'(exp_addr));
      checkOne({tag, ".pos"},  longint'(pos_out),  longint'(exp_pos));
      checkOne({tag, ".zero"}, longint'(zero_out), longint'(exp_zero));
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] d;
      logic [W-1:0] mask;

      errors = 0;
      checks = 0;

      vectors[0] = '{"msb_only",  32'h0000_00A1, 32'h8000_0000, 31, 1'b0};
      vectors[1] = '{"all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 31, 1'b0};
      vectors[2] = '{"bit0_only", 32'h1234_5678, 32'h0000_0001, 0,  1'b0};
      vectors[3] = '{"zero_word", 32'h0000_0007, 32'h0000_0000, 0,  1'b1};
      vectors[4] = '{"val_0x13",  32'hDEAD_BEEF, 32'h0000_0013, 4,  1'b0};
      vectors[5] = '{"bit16",     32'h0000_0002, 32'h0001_0000, 16, 1'b0};
      vectors[6] = '{"low31",     32'h8000_0000, 32'h7FFF_FFFF, 30, 1'b0};
      vectors[7] = '{"nibble0",   32'h5555_AAAA, 32'h0000_000F, 3,  1'b0};

      // Reset held for 100 ns with idle inputs.
      rst_n   = 1'b0;
      addr_in = '0;
      data_in = '0;
      #100;
      exp_addr = '0; exp_pos = '0; exp_zero = 1'b1;
      checkOutput("reset_hold");

      // Release with a zero word: the values stay the same.
      rst_n = 1'b1;
      applyStimulus('0, '0);
      exp_addr = '0; exp_pos = '0; exp_zero = 1'b1;
      checkOutput("reset_release");

      // One-cycle latency and alignment over two back-to-back operands.
      applyStimulus(32'd3, 32'h13);
      exp_addr = 32'd3; exp_pos = 5'd4; exp_zero = 1'b0;
      checkOutput("latency_n");
      applyStimulus(32'd3, 32'h01);
      exp_addr = 32'd3; exp_pos = 5'd0; exp_zero = 1'b0;
      checkOutput("latency_n1");

      // Asynchronous reset between edges while the outputs hold a result.
      applyStimulus(32'd3, 32'h10);
      exp_addr = 32'd3; exp_pos = 5'd4; exp_zero = 1'b0;
      checkOutput("async_before");
      #2;
      rst_n = 1'b0;
      #1;
      exp_addr = '0; exp_pos = '0; exp_zero = 1'b1;
      checkOutput("async_asserted");
      // Inputs present during reset are discarded across the next edges.
      @(posedge clk);
      #1;
      checkOutput("async_held");
      #3;
      rst_n = 1'b1;

      // Boundary and pattern table. The expected values are constants in the table.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vectors[i].addr, vectors[i].data);
         exp_addr = vectors[i].addr;
         exp_pos  = LW'(vectors[i].pos);
         exp_zero = vectors[i].zero;
         checkOutput(vectors[i].name);
      end

      // Walking one with random bits beneath the leading one.
      for (int k = 0; k < W; k++) begin
         mask = (32'h1 << k) - 32'h1;
         d = (32'h1 << k) | ($urandom & mask);
         a = $urandom;
         applyStimulus(a, d);
         checkOne($sformatf("walk%0d.pos", k), longint'(pos_out), longint'(k));
         checkOutput($sformatf("walk%0d", k));
      end

      // Random back-to-back operands, including the small values 0..32.
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0)
            d = W'($urandom_range(0, 32));
         else
            d = $urandom >> $urandom_range(0, 31);
         applyStimulus(a, d);
         checkOutput($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
